rf_write_queue: RTL and testbench
=================================

Name: rf_write_queue

Overview:
- Writer-side companion to the 32x32 register file (x0 hard-wired to zero, 2 async read ports, 1 sync write port).
- Accepts register write requests over a valid/ready handshake and buffers them in an in-order FIFO.
- Drives the register file write port (write/wa/wd), one entry per cycle, whenever the port is not stolen by a higher-priority writer.
- Provides a combinational lookup so readers can bypass pending writes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- XLEN, 32, data width; must match the register file.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  write request valid.
- in_ready  output  1  queue can accept; equals !full.
- in_addr  input  5  destination register.
- in_data  input  XLEN  write data.
- rf_stall  input  1  register file write port busy this cycle; hold head.
- rf_write  output  1  to register file write enable.
- rf_wa  output  5  to register file write address.
- rf_wd  output  XLEN  to register file write data.
- lk_addr  input  5  lookup address (reader bypass).
- lk_hit  output  1  a pending entry targets lk_addr.
- lk_data  output  XLEN  data of youngest pending entry matching lk_addr.
- count  output  $clog2(DEPTH)+1  number of pending entries.
- flush  input  1  only with RFWQ_FLUSH_EN; discard all pending entries.

Behaviour:
- Reset (async, rst_n=0): count=0, pointers=0, all entry valids cleared. Outputs: in_ready=1, rf_write=0, lk_hit=0. rf_wa, rf_wd, lk_data are 0 while empty.
- Enqueue: in_valid && in_ready at a rising edge writes {in_addr, in_data} at the tail. If in_addr==0, the request is accepted (handshake completes) but not stored; count is unchanged.
- Dequeue:
  - rf_write = (count!=0) && !rf_stall, combinational from registered state.
  - rf_wa/rf_wd = head entry, stable while rf_stall=1.
  - The head retires at the edge where rf_write=1.
- Latency: an accepted request is presented on rf_write in the next cycle at the earliest. There is no same-cycle pass-through.
- Full: in_ready=0 when count==DEPTH, even if a dequeue occurs that cycle (no simultaneous enq-on-full). in_ready rises the cycle after a dequeue from full.
- Simultaneous enqueue and dequeue when not full: count unchanged, both pointers advance.
- Pointer wrap: modulo DEPTH; full/empty decided by count, not by pointer equality.
- Lookup (combinational):
  - lk_hit=1 iff lk_addr!=0 and any pending entry matches.
  - lk_data = data of the youngest matching entry; 0 when no hit.
  - The head entry being written this cycle still counts as pending.
  - The input being enqueued this cycle is not visible until the next cycle.
- Ordering: entries retire strictly in acceptance order. Multiple entries to the same address are all written.
- Reset mid-operation: pending entries are lost and rf_write drops immediately (async).

Optional Feature:
- Macro: RFWQ_FLUSH_EN.
- Defined:
  - flush port exists. flush=1 at an edge clears count/pointers/valids.
  - flush has priority over a same-cycle enqueue, which is dropped even though in_ready was 1.
  - rf_write is forced to 0 in the flush cycle; lk_hit is forced to 0 in the flush cycle.
- Undefined: no flush port; queue drains only via the register file write port.

Test Plan:
- Reset, then enqueue (addr 5, 0xDEADBEEF) with rf_stall=0 -> next cycle rf_write=1, rf_wa=5, rf_wd=0xDEADBEEF; following cycle count=0, rf_write=0.
- rf_stall=1, enqueue 4 writes (addr 1..4, data 0x11..0x44) -> count=4, in_ready=0, rf_wa held at 1; drop rf_stall -> addr 1,2,3,4 emitted on consecutive cycles; in_ready=1 one cycle after first retire.
- Enqueue addr 0 data 0xFFFFFFFF -> handshake completes, count stays 0, rf_write never asserts.
- rf_stall=1, enqueue (7, 0xA) then (7, 0xB); lk_addr=7 -> lk_hit=1, lk_data=0xB; lk_addr=0 -> lk_hit=0; release stall -> both writes occur, 0xA then 0xB.
- Continuous enqueue and dequeue for 3*DEPTH requests with alternating rf_stall -> all data retire in order, no loss across pointer wrap.
- With RFWQ_FLUSH_EN: 3 pending entries, assert flush together with in_valid -> next cycle count=0, rf_write=0, lk_hit=0; the same-cycle request is discarded.

Source files
------------

// File: rtl/rf_write_queue.sv
// rtl/rf_write_queue.sv - in-order write queue feeding the 32x32 register file write port
// Optional flush port enabled by defining RFWQ_FLUSH_EN.
module rf_write_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_addr,
    input  logic [XLEN-1:0]          in_data,
    input  logic                     rf_stall,
    output logic                     rf_write,
    output logic [4:0]               rf_wa,
    output logic [XLEN-1:0]          rf_wd,
    input  logic [4:0]               lk_addr,
    output logic                     lk_hit,
    output logic [XLEN-1:0]          lk_data,
`ifdef RFWQ_FLUSH_EN
    input  logic                     flush,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   cnt;
    logic            flush_i;
    logic            empty;
    logic            full;
    logic            enq;
    logic            deq;

`ifdef RFWQ_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign in_ready = !full;
    assign rf_write = !empty && !rf_stall && !flush_i;
    assign rf_wa    = empty ? 5'd0 : addr_q[head];
    assign rf_wd    = empty ? '0 : data_q[head];
    assign count    = cnt;

    // Writes to x0 complete the handshake but are never stored.
    assign enq = in_valid && in_ready && (in_addr != 5'd0) && !flush_i;
    assign deq = rf_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            valid_q <= '0;
        end else if (flush_i) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            valid_q <= '0;
        end else begin
            if (enq) begin
                valid_q[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
            if (deq) begin
                valid_q[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            unique case ({enq, deq})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= in_addr;
            data_q[tail] <= in_data;
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest.
    logic [PW-1:0] idx;
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid_q[idx] && (addr_q[idx] == lk_addr) && (lk_addr != 5'd0)) begin
                lk_hit  = 1'b1;
                lk_data = data_q[idx];
            end
        end
        if (flush_i) begin
            lk_hit  = 1'b0;
            lk_data = '0;
        end
    end

endmodule

// File: tb/tb_rf_write_queue.sv
// tb/tb_rf_write_queue.sv - self-checking bench for rf_write_queue against a queue model
module tb_rf_write_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      in_addr = '0;
    logic [XLEN-1:0] in_data = '0;
    logic            rf_stall = 1'b0;
    logic            rf_write;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic [4:0]      lk_addr = '0;
    logic            lk_hit;
    logic [XLEN-1:0] lk_data;
    logic [CW-1:0]   count;
`ifdef RFWQ_FLUSH_EN
    logic            flush = 1'b0;
`endif

    rf_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .rf_stall (rf_stall),
        .rf_write (rf_write),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd),
        .lk_addr  (lk_addr),
        .lk_hit   (lk_hit),
        .lk_data  (lk_data),
`ifdef RFWQ_FLUSH_EN
        .flush    (flush),
`endif
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      a;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t mq[$];
    int tests = 0;
    int fails = 0;

    logic            obs_ready, obs_write, obs_hit;
    logic [4:0]      obs_wa;
    logic [XLEN-1:0] obs_wd, obs_data;
    logic [CW-1:0]   obs_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [4:0] a, input logic [XLEN-1:0] d,
                         input logic st, input logic [4:0] lka, input logic fl);
        logic            e_ready, e_write, e_hit, fl_eff;
        logic [4:0]      e_wa;
        logic [XLEN-1:0] e_wd, e_data;
        @(negedge clk);
        in_valid = v; in_addr = a; in_data = d; rf_stall = st; lk_addr = lka;
`ifdef RFWQ_FLUSH_EN
        flush  = fl;
        fl_eff = fl;
`else
        fl_eff = 1'b0;
`endif
        #1;
        e_ready = (mq.size() < DEPTH);
        e_write = (mq.size() != 0) && !st && !fl_eff;
        e_wa    = (mq.size() != 0) ? mq[0].a : 5'd0;
        e_wd    = (mq.size() != 0) ? mq[0].d : '0;
        e_hit   = 1'b0;
        e_data  = '0;
        if (lka != 5'd0 && !fl_eff)
            foreach (mq[i])
                if (mq[i].a == lka) begin
                    e_hit  = 1'b1;
                    e_data = mq[i].d;
                end
        chk("in_ready", in_ready, e_ready);
        chk("rf_write", rf_write, e_write);
        chk("rf_wa",    rf_wa,    e_wa);
        chk("rf_wd",    rf_wd,    e_wd);
        chk("count",    count,    mq.size());
        chk("lk_hit",   lk_hit,   e_hit);
        chk("lk_data",  lk_data,  e_data);
        obs_ready = in_ready; obs_write = rf_write; obs_wa = rf_wa; obs_wd = rf_wd;
        obs_count = count; obs_hit = lk_hit; obs_data = lk_data;
        @(posedge clk);
        if (fl_eff) begin
            mq.delete();
        end else begin
            if (e_write) void'(mq.pop_front());
            if (v && e_ready && a != 5'd0) mq.push_back('{a: a, d: d});
        end
    endtask

    task automatic idle(input logic st, input logic [4:0] lka);
        cycle(1'b0, 5'd0, '0, st, lka, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_rf_write", rf_write, 1'b0);
        chk("rst_lk_hit",   lk_hit,   1'b0);
        chk("rst_count",    count,    0);
        chk("rst_rf_wd",    rf_wd,    0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write, next-cycle presentation, then empty.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        chk("t1_no_passthru", obs_write, 1'b0);
        idle(1'b0, 5'd0);
        chk("t1_write", obs_write, 1'b1);
        chk("t1_wa",    obs_wa,    5'd5);
        chk("t1_wd",    obs_wd,    32'hDEADBEEF);
        idle(1'b0, 5'd0);
        chk("t1_count_after", obs_count, 0);
        chk("t1_write_after", obs_write, 1'b0);

        // Fill under stall, then drain in order.
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 5'(i), 32'(i * 'h11), 1'b1, 5'd0, 1'b0);
        cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd0, 1'b0);
        chk("t2_count_full", obs_count, 4);
        chk("t2_ready_full", obs_ready, 1'b0);
        chk("t2_wa_held",    obs_wa,    5'd1);
        for (int i = 1; i <= 4; i++) begin
            idle(1'b0, 5'd0);
            chk("t2_drain_wa", obs_wa, 5'(i));
            chk("t2_drain_wd", obs_wd, 32'(i * 'h11));
            chk("t2_ready", obs_ready, (i == 1) ? 1'b0 : 1'b1);
        end

        // Write to x0 is accepted and dropped.
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0);
        chk("t3_ready", obs_ready, 1'b1);
        idle(1'b0, 5'd0);
        chk("t3_count", obs_count, 0);
        chk("t3_write", obs_write, 1'b0);

        // Lookup returns youngest of two writes to x7.
        cycle(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 1'b0);
        chk("t4_not_visible", obs_hit, 1'b0);
        cycle(1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 1'b0);
        idle(1'b1, 5'd7);
        chk("t4_hit",  obs_hit,  1'b1);
        chk("t4_data", obs_data, 32'hB);
        idle(1'b1, 5'd0);
        chk("t4_x0_hit", obs_hit, 1'b0);
        idle(1'b0, 5'd7);
        chk("t4_first",  obs_wd, 32'hA);
        chk("t4_head_pending", obs_data, 32'hB);
        idle(1'b0, 5'd7);
        chk("t4_second", obs_wd, 32'hB);
        idle(1'b0, 5'd0);

        // Streaming across pointer wrap with alternating stall.
        for (int i = 0; i < 3 * DEPTH * 2; i++)
            cycle(1'b1, 5'($urandom_range(1, 31)), $urandom, i[0], 5'($urandom_range(0, 31)), 1'b0);
        repeat (DEPTH + 1) idle(1'b0, 5'd0);
        chk("t5_drained", obs_count, 0);

        // Random traffic over a small address set to exercise lookups.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 4)), $urandom,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 5)), 1'b0);

`ifdef RFWQ_FLUSH_EN
        while (mq.size() != 0) idle(1'b0, 5'd0);
        for (int i = 1; i <= 3; i++)
            cycle(1'b1, 5'(i + 10), 32'(i), 1'b1, 5'd0, 1'b0);
        cycle(1'b1, 5'd12, 32'h55, 1'b0, 5'd12, 1'b1);
        chk("t6_flush_write", obs_write, 1'b0);
        chk("t6_flush_hit",   obs_hit,   1'b0);
        idle(1'b0, 5'd12);
        chk("t6_count", obs_count, 0);
        chk("t6_write", obs_write, 1'b0);
        chk("t6_hit",   obs_hit,   1'b0);
`endif

        // Asynchronous reset with pending entries.
        for (int i = 1; i <= 2; i++)
            cycle(1'b1, 5'(i + 20), 32'(i), 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; rf_stall = 1'b0; lk_addr = 5'd21;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_write_drop", rf_write, 1'b0);
        chk("t7_count",      count,    0);
        chk("t7_hit",        lk_hit,   1'b0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0, 5'd21);
        chk("t7_empty", obs_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
